// File: rtl/scaler_vpos_gen_if.sv
// Vertical scaler position bundle: latched frame configuration and line requests in, per-line source pair and blend phase out.
interface scaler_vpos_gen_if #(parameter int PHASE_W = 8);
    logic [8:0]         vpos_1st_rdline_i;
    logic [8:0]         vlines_in_needed_i;
    logic [10:0]        vlines_out_i;
    logic [17:0]        v_interp_factor_i;
    logic               frame_start_i;
    logic               line_req_i;
    logic [8:0]         rdline_a_o;
    logic [8:0]         rdline_b_o;
    logic [PHASE_W-1:0] v_phase_o;
    logic               line_valid_o;
    logic               frame_done_o;
    logic               ovf_o;

    modport master (
        output vpos_1st_rdline_i, vlines_in_needed_i, vlines_out_i, v_interp_factor_i,
               frame_start_i, line_req_i,
        input  rdline_a_o, rdline_b_o, v_phase_o, line_valid_o, frame_done_o, ovf_o
    );

    modport slave (
        input  vpos_1st_rdline_i, vlines_in_needed_i, vlines_out_i, v_interp_factor_i,
               frame_start_i, line_req_i,
        output rdline_a_o, rdline_b_o, v_phase_o, line_valid_o, frame_done_o, ovf_o
    );
endinterface

// File: rtl/scaler_vpos_gen.sv
// Per-output-line vertical source pair + blend phase; 2-cycle request-to-valid, one line per cycle, no backpressure.
// SCALER_VPOS_CENTER_EN selects centre-aligned sampling (default: top-aligned).
module scaler_vpos_gen #(
    parameter int PHASE_W = 8
) (
    input  logic              SYS_CLK,
    input  logic              SYS_RST,
    scaler_vpos_gen_if.slave  io_vpos
);
    localparam int FRAC_LSB = 17 - PHASE_W;

    typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_RUN, ST_DONE} state_t;

    state_t              r_state, w_state_nxt;
    logic                r_setup_cyc;
    logic [8:0]          r_1st, r_needed;
    logic [10:0]         r_out, r_cnt;
    logic [17:0]         r_factor;
    logic [26:0]         r_step;
    logic signed [28:0]  r_acc, r_s1_acc;
    logic                r_pend, r_s1_vld;
    logic                r_vld, r_done, r_ovf;
    logic [8:0]          r_rdline_a, r_rdline_b;
    logic [PHASE_W-1:0]  r_phase;

    logic                w_take, w_ovf_set, w_last;
    logic [26:0]         w_step;
    logic signed [28:0]  w_acc0;
    logic [10:0]         w_int;
    logic [PHASE_W-1:0]  w_frac, w_ph;
    logic [8:0]          w_nm1, w_a, w_b;

    assign w_step = r_needed * r_factor;
`ifdef SCALER_VPOS_CENTER_EN
    // Half an output line minus half a source line; negative offsets clamp to the first line.
    assign w_acc0 = $signed({3'b000, r_step[26:1]}) - 29'sd65536;
`else
    assign w_acc0 = 29'sd0;
`endif
    assign w_last = ({1'b0, r_cnt} + 12'd1) >= {1'b0, r_out};

    always_comb begin
        w_state_nxt = r_state;
        w_take      = 1'b0;
        w_ovf_set   = 1'b0;
        case (r_state)
            ST_SETUP: if (r_setup_cyc) w_state_nxt = ST_RUN;
            ST_RUN: begin
                w_take = r_pend | io_vpos.line_req_i;
                if (w_take && w_last) w_state_nxt = ST_DONE;
            end
            ST_DONE:  w_ovf_set = io_vpos.line_req_i;
            default:  ;
        endcase
        if (io_vpos.frame_start_i) begin
            w_state_nxt = ST_SETUP;
            w_take      = 1'b0;
            w_ovf_set   = 1'b0;
        end
    end

    always_ff @(posedge SYS_CLK or posedge SYS_RST) begin
        if (SYS_RST) r_state <= ST_IDLE;
        else         r_state <= w_state_nxt;
    end

    assign w_int  = r_s1_acc[27:17];
    assign w_frac = r_s1_acc[16:FRAC_LSB];
    assign w_nm1  = r_needed - 9'd1;

    always_comb begin
        w_a  = '0;
        w_b  = '0;
        w_ph = '0;
        if (!r_s1_acc[28]) begin
            if (w_int >= {2'b00, w_nm1}) begin
                w_a = w_nm1;
                w_b = w_nm1;
            end else begin
                w_a  = w_int[8:0];
                w_b  = w_int[8:0] + 9'd1;
                w_ph = w_frac;
            end
        end
    end

    always_ff @(posedge SYS_CLK or posedge SYS_RST) begin
        if (SYS_RST) begin
            r_setup_cyc <= 1'b0;
            r_1st       <= '0;
            r_needed    <= '0;
            r_out       <= '0;
            r_factor    <= '0;
            r_step      <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_pend      <= 1'b0;
            r_s1_vld    <= 1'b0;
            r_s1_acc    <= '0;
            r_vld       <= 1'b0;
            r_done      <= 1'b0;
            r_ovf       <= 1'b0;
            r_rdline_a  <= '0;
            r_rdline_b  <= '0;
            r_phase     <= '0;
        end else begin
            r_vld <= 1'b0;
            if (io_vpos.frame_start_i) begin
                r_1st       <= io_vpos.vpos_1st_rdline_i;
                r_needed    <= io_vpos.vlines_in_needed_i;
                r_out       <= io_vpos.vlines_out_i;
                r_factor    <= io_vpos.v_interp_factor_i;
                r_cnt       <= '0;
                r_pend      <= 1'b0;
                r_s1_vld    <= 1'b0;
                r_done      <= 1'b0;
                r_ovf       <= 1'b0;
                r_setup_cyc <= 1'b0;
            end else begin
                if (r_state == ST_SETUP) begin
                    r_pend <= r_pend | io_vpos.line_req_i;
                    if (!r_setup_cyc) begin
                        r_step      <= w_step;
                        r_setup_cyc <= 1'b1;
                    end else begin
                        r_acc <= w_acc0;
                    end
                end
                // A pending and a live request together leave the live one pending.
                if (r_state == ST_RUN) r_pend <= r_pend & io_vpos.line_req_i;
                r_s1_vld <= w_take;
                if (w_take) begin
                    r_s1_acc <= r_acc;
                    r_acc    <= r_acc + $signed({2'b00, r_step});
                    r_cnt    <= r_cnt + 11'd1;
                    if (w_last) r_done <= 1'b1;
                end
                if (w_ovf_set) r_ovf <= 1'b1;
                if (r_s1_vld) begin
                    r_vld      <= 1'b1;
                    r_rdline_a <= r_1st + w_a;
                    r_rdline_b <= r_1st + w_b;
                    r_phase    <= w_ph;
                end
            end
        end
    end

    assign io_vpos.rdline_a_o   = r_rdline_a;
    assign io_vpos.rdline_b_o   = r_rdline_b;
    assign io_vpos.v_phase_o    = r_phase;
    assign io_vpos.line_valid_o = r_vld;
    assign io_vpos.frame_done_o = r_done;
    assign io_vpos.ovf_o        = r_ovf;
endmodule
